// File: rtl/collatz_pkg.sv
// Shared types and constants for the Collatz sweep core.
//   state_t      : top-level sweep FSM states
//   ALERT_*      : result / alert codes reported by engines and the core
//   SEL_*        : data_out source selection codes
package collatz_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0] ALERT_NONE    = 2'b00;
   localparam logic [1:0] ALERT_OVF     = 2'b01;
   localparam logic [1:0] ALERT_TIMEOUT = 2'b10;

   localparam logic [1:0] SEL_TESTED = 2'd0;
   localparam logic [1:0] SEL_MAXV   = 2'd1;
   localparam logic [1:0] SEL_MAXS   = 2'd2;
   localparam logic [1:0] SEL_ALERT  = 2'd3;

endpackage

// File: rtl/collatz_engine.sv
// One iterative Collatz engine: one trajectory step per cycle with a step watchdog.
//   clock, clear_n : clock, async active-low reset
//   load, value    : start a new trajectory from value (only while idle)
//   ack            : result accepted; engine is idle from the next cycle
//   idle           : ready for load
//   valid          : result held (res_value = start value, res_steps, res_code)
module collatz_engine
   import collatz_pkg::*;
#(
   parameter int W      = 32,
   parameter int STEP_W = 16,
   parameter int LIMIT  = 1000
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              load,
   input  logic [W-1:0]      value,
   input  logic              ack,
   output logic              idle,
   output logic              valid,
   output logic [W-1:0]      res_value,
   output logic [STEP_W-1:0] res_steps,
   output logic [1:0]        res_code
);

   logic              busy_q,  busy_d;
   logic              valid_q, valid_d;
   logic [W-1:0]      x_q,     x_d;
   logic [W-1:0]      v_q,     v_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic [1:0]        code_q,  code_d;
   logic [W+1:0]      x3;

   always_comb begin
      busy_d  = busy_q;
      valid_d = valid_q;
      x_d     = x_q;
      v_d     = v_q;
      steps_d = steps_q;
      code_d  = code_q;
      // 3x+1 with two guard bits so a carry past W is visible
      x3      = ({2'b00, x_q} << 1) + {2'b00, x_q} + (W+2)'(1);

      if (load) begin
         busy_d  = 1'b1;
         valid_d = 1'b0;
         x_d     = value;
         v_d     = value;
         steps_d = '0;
         code_d  = ALERT_NONE;
      end else if (busy_q) begin
         if (x_q == W'(1)) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
            code_d  = ALERT_NONE;
         end else if (x_q == '0 || steps_q == STEP_W'(LIMIT)) begin
            // zero never converges, so it is reported as a timeout at once
            busy_d  = 1'b0;
            valid_d = 1'b1;
            code_d  = ALERT_TIMEOUT;
         end else if (x_q[0]) begin
            if (x3[W+1:W] != 2'b00) begin
               busy_d  = 1'b0;
               valid_d = 1'b1;
               code_d  = ALERT_OVF;
            end else begin
               x_d     = x3[W-1:0];
               steps_d = steps_q + STEP_W'(1);
            end
         end else begin
            x_d     = x_q >> 1;
            steps_d = steps_q + STEP_W'(1);
         end
      end else if (valid_q && ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         x_q     <= '0;
         v_q     <= '0;
         steps_q <= '0;
         code_q  <= ALERT_NONE;
      end else begin
         busy_q  <= busy_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         v_q     <= v_d;
         steps_q <= steps_d;
         code_q  <= code_d;
      end
   end

   assign idle      = !busy_q && !valid_q;
   assign valid     = valid_q;
   assign res_value = v_q;
   assign res_steps = steps_q;
   assign res_code  = code_q;

endmodule

// File: rtl/collatz_sweep.sv
// Multi-engine Collatz sweep: dispatches COUNT start values from BASE to
// ENGINES parallel engines, retires one result per cycle and aggregates
// tested count, longest stopping time and the first failure.
//   clock, clear_n    : clock, async active-low reset
//   start, stop       : begin sweep (IDLE/DONE only) / stop issuing and drain
//   base, count       : sweep range, sampled on accepted start
//   select            : data_out source (tested, max_value, max_steps, alert_value)
//   busy, done        : RUN/DRAIN, DONE
//   alert, alert_code, alert_value : first failure of this sweep
//   max_steps, max_value, tested   : aggregate results
//   data_out          : combinational mux of the registered results
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | issuing values to idle engines
// DRAIN | no more issue; retiring in-flight results
// DONE  | all results retired; waiting for start
module collatz_sweep
   import collatz_pkg::*;
#(
   parameter int W       = 32,
   parameter int ENGINES = 4,
   parameter int STEP_W  = 16,
   parameter int LIMIT   = 1000
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              start,
   input  logic              stop,
   input  logic [W-1:0]      base,
   input  logic [W-1:0]      count,
   input  logic [1:0]        select,
   output logic              busy,
   output logic              done,
   output logic              alert,
   output logic [1:0]        alert_code,
   output logic [W-1:0]      alert_value,
   output logic [STEP_W-1:0] max_steps,
   output logic [W-1:0]      max_value,
   output logic [W-1:0]      tested,
   output logic [W-1:0]      data_out
);

   state_t            state_q, state_d;
   logic [W-1:0]      ptr_q, ptr_d;
   logic [W-1:0]      remaining_q, remaining_d;
   logic [W-1:0]      tested_q, tested_d;
   logic [STEP_W-1:0] max_steps_q, max_steps_d;
   logic [W-1:0]      max_value_q, max_value_d;
   logic              alert_q, alert_d;
   logic [1:0]        alert_code_q, alert_code_d;
   logic [W-1:0]      alert_value_q, alert_value_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [ENGINES-1:0] eng_idle, eng_valid, eng_load, eng_ack, idle_sel;
   logic [W-1:0]       eng_res_value [ENGINES];
   logic [STEP_W-1:0]  eng_res_steps [ENGINES];
   logic [1:0]         eng_res_code  [ENGINES];

   logic              issue_ok, found_idle, acc_any;
   logic [W-1:0]      acc_value;
   logic [STEP_W-1:0] acc_steps;
   logic [1:0]        acc_code;

   for (genvar g = 0; g < ENGINES; g++) begin : g_eng
      collatz_engine #(.W(W), .STEP_W(STEP_W), .LIMIT(LIMIT)) u_eng (
         .clock     (clock),
         .clear_n   (clear_n),
         .load      (eng_load[g]),
         .value     (ptr_q),
         .ack       (eng_ack[g]),
         .idle      (eng_idle[g]),
         .valid     (eng_valid[g]),
         .res_value (eng_res_value[g]),
         .res_steps (eng_res_steps[g]),
         .res_code  (eng_res_code[g])
      );
   end

   // lowest-index idle engine for issue, lowest-index valid engine for accept
   always_comb begin
      idle_sel   = '0;
      found_idle = 1'b0;
      eng_ack    = '0;
      acc_any    = 1'b0;
      acc_value  = '0;
      acc_steps  = '0;
      acc_code   = ALERT_NONE;
      for (int i = 0; i < ENGINES; i++) begin
         if (eng_idle[i] && !found_idle) begin
            idle_sel[i] = 1'b1;
            found_idle  = 1'b1;
         end
         if (eng_valid[i] && !acc_any) begin
            eng_ack[i] = 1'b1;
            acc_any    = 1'b1;
            acc_value  = eng_res_value[i];
            acc_steps  = eng_res_steps[i];
            acc_code   = eng_res_code[i];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      remaining_d   = remaining_q;
      tested_d      = tested_q;
      max_steps_d   = max_steps_q;
      max_value_d   = max_value_q;
      alert_d       = alert_q;
      alert_code_d  = alert_code_q;
      alert_value_d = alert_value_q;
      eng_load      = '0;
      issue_ok      = (state_q == RUN) && (remaining_q != '0) && !stop && !alert_q;

      if (acc_any) begin
         tested_d = tested_q + W'(1);
         if (acc_code == ALERT_NONE) begin
            if (acc_steps > max_steps_q ||
                (acc_steps == max_steps_q && acc_value < max_value_q)) begin
               max_steps_d = acc_steps;
               max_value_d = acc_value;
            end
         end else if (!alert_q) begin
            alert_d       = 1'b1;
            alert_code_d  = acc_code;
            alert_value_d = acc_value;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               ptr_d         = base;
               remaining_d   = count;
               tested_d      = '0;
               max_steps_d   = '0;
               max_value_d   = '0;
               alert_d       = 1'b0;
               alert_code_d  = ALERT_NONE;
               alert_value_d = '0;
               state_d       = RUN;
            end
         end
         RUN: begin
            if (!issue_ok) begin
               state_d = DRAIN;
            end else if (found_idle) begin
               eng_load    = idle_sel;
               ptr_d       = ptr_q + W'(1);
               remaining_d = remaining_q - W'(1);
            end
         end
         DRAIN: begin
            if (&eng_idle) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         remaining_q   <= '0;
         tested_q      <= '0;
         max_steps_q   <= '0;
         max_value_q   <= '0;
         alert_q       <= 1'b0;
         alert_code_q  <= ALERT_NONE;
         alert_value_q <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         remaining_q   <= remaining_d;
         tested_q      <= tested_d;
         max_steps_q   <= max_steps_d;
         max_value_q   <= max_value_d;
         alert_q       <= alert_d;
         alert_code_q  <= alert_code_d;
         alert_value_q <= alert_value_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign alert       = alert_q;
   assign alert_code  = alert_code_q;
   assign alert_value = alert_value_q;
   assign max_steps   = max_steps_q;
   assign max_value   = max_value_q;
   assign tested      = tested_q;

   always_comb begin
      case (select)
         SEL_TESTED: data_out = tested_q;
         SEL_MAXV:   data_out = max_value_q;
         SEL_MAXS:   data_out = W'(max_steps_q);
         default:    data_out = alert_value_q;
      endcase
   end

endmodule

// File: doc/collatz_sweep.md
Name: collatz_sweep

Overview:
Parametrised multi-engine Collatz (Ulam) sweep core, the successor to the single-value collatzTest/watchdog/control chain. Tests COUNT consecutive start values from BASE across ENGINES parallel iterative engines. Each engine has a per-value step watchdog. The core tracks the longest stopping time, its start value, the count of values tested, and the first failure. A select-driven output feeds the existing bin2bcd/bcd7seg display path.

Parameters:
W, 32, value width (start values and trajectory values)
ENGINES, 4, number of parallel engines (1..16)
STEP_W, 16, step counter width
LIMIT, 1000, watchdog step limit per value (must be < 2**STEP_W)

Ports:
clock  input  1  system clock; all state on rising edge
clear_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE or DONE
stop  input  1  stop issuing new values; drain, then DONE
base  input  W  first start value; sampled on accepted start
count  input  W  number of values to test; sampled on accepted start
select  input  2  display source: 0 tested, 1 max_value, 2 max_steps, 3 alert_value
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE; level, cleared by next accepted start
alert  output  1  sticky; first failure seen this sweep
alert_code  output  2  00 none, 01 overflow, 10 watchdog timeout
alert_value  output  W  start value of the first failure
max_steps  output  STEP_W  longest stopping time seen
max_value  output  W  start value that produced max_steps
tested  output  W  results retired this sweep
data_out  output  W  select mux of the above; max_steps zero-extended

Behaviour:
- Async reset (clear_n=0): FSM to IDLE, all engines idle, every output and register 0.
- Top FSM has four states: IDLE, RUN, DRAIN, DONE.
- start in IDLE or DONE: latch base/count, clear tested/max/alert, enter RUN next cycle. start in RUN/DRAIN is ignored.
- RUN: at most one issue per cycle, to the lowest-index idle engine. The issue pointer increments; remaining decrements.
- RUN -> DRAIN when remaining hits 0, when stop=1, or when an alert is latched. DRAIN -> DONE when all engines are idle and no result is pending. count=0 gives RUN -> DRAIN -> DONE with tested=0.
- Engine load sets x=v and steps=0, then takes one step per cycle:
  - x==1: finish OK with the current steps. v=1 finishes with steps=0 on its first cycle.
  - x even: x = x>>1.
  - x odd: x = 3x+1, computed at W+2 bits. A result >= 2**W finishes with overflow.
  - steps increments per step. steps==LIMIT before reaching 1 finishes with timeout.
  - v=0 finishes with timeout in one cycle (never converges).
- Engine result (value, steps, code) is held until accepted. Accept one result per cycle, lowest index first; the engine goes idle on the accept cycle and may be reloaded the next cycle.
- On accept: tested += 1.
  - OK and steps > max_steps, or steps == max_steps with value < max_value: update max_steps and max_value.
  - Error with alert=0: latch alert, alert_code and alert_value. Later errors are counted but not latched.
- The issue pointer wraps modulo 2**W. The wrap value is still tested; nothing is flagged.
- Outputs are registered, except data_out, which is a combinational mux of registered values.
- Reset mid-sweep aborts immediately; no partial result is retained.

Decomposition:
- Package collatz_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - alert code constants (ALERT_NONE, ALERT_OVF, ALERT_TIMEOUT);
  - select constants (SEL_TESTED, SEL_MAXV, SEL_MAXS, SEL_ALERT).
- Sub-module collatz_engine: one iterative engine, parameters W, STEP_W and LIMIT.
  - Inputs: load, value, ack.
  - Outputs: idle, valid, result value, result steps, result code.
- The top level instantiates ENGINES copies of collatz_engine and contains the dispatcher, the result arbiter and the aggregator.

Test Plan:
- base=27, count=1 -> done; tested=1, max_steps=111, max_value=27, alert=0; data_out with select=2 is 111.
- base=1, count=10, ENGINES=4 -> tested=10, max_steps=19, max_value=9, alert=0.
- LIMIT=100, base=27, count=1 -> alert=1, alert_code=10, alert_value=27, tested=1, max_steps=0.
- W=8, base=27, count=1 (322 exceeds 8 bits) -> alert_code=01, alert_value=27; RUN->DRAIN on alert; done=1.
- base=1, count=1000, stop pulsed after 20 cycles -> issuing stops, all in-flight values retire, done=1, tested equals the issued count (< 1000); a start pulse while busy has no effect.
- Sweep base=1, count=50, clear_n pulsed low mid-run -> every output 0 immediately; a fresh start with count=0 -> done=1 within 3 cycles, tested=0.
